ocl_axil_decoder: RTL and testbench

OCL_AXIL_DECODER -- requirements
Module: ocl_axil_decoder

---
 rtl/ocl_axil_pkg.sv | 29 ++
 rtl/ocl_axil_timeout.sv | 28 ++
 rtl/ocl_axil_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_ocl_axil_decoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocl_axil_pkg.sv
// Shared types and constants for the OCL AXI-Lite register decoder.
// Holds the response encodings, FSM state enums and the read error pattern.
package ocl_axil_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'd0;
  localparam logic [1:0]  RESP_SLVERR = 2'd2;
  localparam logic [1:0]  RESP_DECERR = 2'd3;
  localparam logic [31:0] BAD_DATA    = 32'hBAD0_BAD0;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_STROBE = 2'd1,
    W_RESP   = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

  // 16-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/ocl_axil_timeout.sv
// Down-counter guarding a channel read: loaded on request, decremented while
// waiting, and expire is high once it has run down to zero.
module ocl_axil_timeout #(
  parameter int TIMEOUT = 255,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk_main_a0,
  input  logic rst_main_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= CW'(TIMEOUT);
    end else if (count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/ocl_axil_decoder.sv
// AXI-Lite slave that splits the address space into N_CH register regions and
// forwards writes/reads as simple strobe/request interfaces to each channel.
module ocl_axil_decoder
  import ocl_axil_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int REGION_AW = 12,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk_main_a0,
  input  logic                   rst_main_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [31:0]            awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [1:0]             bresp,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [31:0]            araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [31:0]            rdata,
  output logic [1:0]             rresp,
  output logic [N_CH-1:0]        ch_wr_en,
  output logic [REGION_AW-1:0]   ch_waddr,
  output logic [31:0]            ch_wdata,
  output logic [3:0]             ch_wstrb,
  output logic [N_CH-1:0]        ch_rd_en,
  output logic [REGION_AW-1:0]   ch_raddr,
  input  logic [32*N_CH-1:0]     ch_rdata,
  input  logic [N_CH-1:0]        ch_rvalid,
  output logic [15:0]            err_cnt
);

  // Reset asserts immediately but releases only after two clean clock edges.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) r_rst_sync <= 2'b00;
    else             r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // ---------------- write path ----------------
  w_state_t       r_w_state, w_state_next;
  logic           r_aw_got, r_w_got;
  logic [31:0]    r_awaddr, r_wdata;
  logic [3:0]     r_wstrb;
  logic [1:0]     r_bresp;
  logic           w_aw_hs, w_w_hs, w_wr_go, w_wr_derr;
  logic [3:0]     w_wr_idx;

  assign awready   = (r_w_state == W_IDLE) && !r_aw_got;
  assign wready    = (r_w_state == W_IDLE) && !r_w_got;
  assign w_aw_hs   = awvalid && awready;
  assign w_w_hs    = wvalid && wready;
  assign w_wr_go   = (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
  assign w_wr_idx  = r_awaddr[REGION_AW+3:REGION_AW];
  assign w_wr_derr = (int'(w_wr_idx) >= N_CH) || (|r_awaddr[31:REGION_AW+4]);

  always_comb begin
    w_state_next = r_w_state;
    case (r_w_state)
      W_IDLE:   if (w_wr_go) w_state_next = W_STROBE;
      W_STROBE: w_state_next = W_RESP;
      W_RESP:   if (bready) w_state_next = W_IDLE;
      default:  w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_w_state <= W_IDLE;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_w_state <= w_state_next;
      if (w_aw_hs) r_awaddr <= awaddr;
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_wr_go) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_got <= 1'b1;
        if (w_w_hs)  r_w_got  <= 1'b1;
      end
      if (r_w_state == W_STROBE) r_bresp <= w_wr_derr ? RESP_DECERR : RESP_OKAY;
    end
  end

  assign bvalid   = (r_w_state == W_RESP);
  assign bresp    = r_bresp;
  assign ch_waddr = r_awaddr[REGION_AW-1:0];
  assign ch_wdata = r_wdata;
  assign ch_wstrb = r_wstrb;

  // ---------------- read path ----------------
  r_state_t              r_r_state, r_state_next;
  logic [3:0]            r_rd_idx;
  logic                  r_rd_derr, r_rd_pulse;
  logic [REGION_AW-1:0]  r_raddr;
  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;
  logic                  w_ar_hs, w_ar_derr, w_sel_rvalid, w_tmo_expire, w_rd_done;
  logic [3:0]            w_ar_idx;
  logic [N_CH-1:0]       w_rd_hit;
  logic [31:0]           w_ch_rdata_masked [N_CH];
  logic [31:0]           w_sel_rdata, w_rdata_next;
  logic [1:0]            w_rresp_next;

  assign arready   = (r_r_state == R_IDLE);
  assign w_ar_hs   = arvalid && arready;
  assign w_ar_idx  = araddr[REGION_AW+3:REGION_AW];
  assign w_ar_derr = (int'(w_ar_idx) >= N_CH) || (|araddr[31:REGION_AW+4]);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign ch_wr_en[gi] = (r_w_state == W_STROBE) && !w_wr_derr && (w_wr_idx == 4'(gi));
    assign w_rd_hit[gi] = (r_rd_idx == 4'(gi));
    assign ch_rd_en[gi] = r_rd_pulse && w_rd_hit[gi];
    assign w_ch_rdata_masked[gi] = w_rd_hit[gi] ? ch_rdata[32*gi +: 32] : 32'd0;
  end

  always_comb begin
    w_sel_rdata = 32'd0;
    for (int i = 0; i < N_CH; i++) w_sel_rdata = w_sel_rdata | w_ch_rdata_masked[i];
  end

  // Only the addressed channel's done flag matters, and only while waiting.
  assign w_sel_rvalid = |(ch_rvalid & w_rd_hit);

  ocl_axil_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_main_a0 (clk_main_a0),
    .rst_main_n  (w_rst_n),
    .load        (w_ar_hs),
    .count       (r_r_state == R_WAIT),
    .expire      (w_tmo_expire)
  );

  always_comb begin
    r_state_next = r_r_state;
    w_rd_done    = 1'b0;
    w_rresp_next = RESP_OKAY;
    w_rdata_next = BAD_DATA;
    case (r_r_state)
      R_IDLE: if (w_ar_hs) r_state_next = R_WAIT;
      R_WAIT: begin
        if (r_rd_derr) begin
          w_rd_done    = 1'b1;
          w_rresp_next = RESP_DECERR;
        end else if (w_sel_rvalid) begin
          w_rd_done    = 1'b1;
          w_rdata_next = w_sel_rdata;
        end else if (w_tmo_expire) begin
          w_rd_done    = 1'b1;
          w_rresp_next = RESP_SLVERR;
        end
        if (w_rd_done) r_state_next = R_RESP;
      end
      R_RESP: if (rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_r_state  <= R_IDLE;
      r_rd_idx   <= '0;
      r_rd_derr  <= 1'b0;
      r_rd_pulse <= 1'b0;
      r_raddr    <= '0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_r_state  <= r_state_next;
      r_rd_pulse <= w_ar_hs && !w_ar_derr;
      if (w_ar_hs) begin
        r_rd_idx  <= w_ar_idx;
        r_rd_derr <= w_ar_derr;
        r_raddr   <= araddr[REGION_AW-1:0];
      end
      if (w_rd_done) begin
        r_rdata <= w_rdata_next;
        r_rresp <= w_rresp_next;
      end
    end
  end

  assign rvalid   = (r_r_state == R_RESP);
  assign rdata    = r_rdata;
  assign rresp    = r_rresp;
  assign ch_raddr = r_raddr;

  // ---------------- error counter ----------------
  logic [15:0] r_err_cnt;
  logic [1:0]  w_err_inc;

  assign w_err_inc = {1'b0, (r_w_state == W_STROBE) && w_wr_derr}
                   + {1'b0, w_rd_done && (w_rresp_next != RESP_OKAY)};

  always_ff @(posedge clk_main_a0 or negedge w_rst_n) begin
    if (!w_rst_n) r_err_cnt <= '0;
    else          r_err_cnt <= sat_add16(r_err_cnt, w_err_inc);
  end

  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_ocl_axil_decoder.sv
// Directed bench for ocl_axil_decoder: writes, reads, timeout, decode errors,
// back-pressure on both response channels and reset during a pending read.
module tb_ocl_axil_decoder;

  localparam int N_CH      = 4;
  localparam int REGION_AW = 12;
  localparam int TIMEOUT   = 8;

  logic                  clk_main_a0;
  logic                  rst_main_n;
  logic                  awvalid, awready, wvalid, wready, bvalid, bready;
  logic                  arvalid, arready, rvalid, rready;
  logic [31:0]           awaddr, wdata, araddr, rdata;
  logic [3:0]            wstrb, ch_wstrb;
  logic [1:0]            bresp, rresp;
  logic [N_CH-1:0]       ch_wr_en, ch_rd_en, ch_rvalid;
  logic [REGION_AW-1:0]  ch_waddr, ch_raddr;
  logic [31:0]           ch_wdata;
  logic [32*N_CH-1:0]    ch_rdata;
  logic [15:0]           err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ocl_axil_decoder #(.N_CH(N_CH), .REGION_AW(REGION_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_main_a0 (clk_main_a0), .rst_main_n (rst_main_n),
    .awvalid (awvalid), .awready (awready), .awaddr (awaddr),
    .wvalid (wvalid), .wready (wready), .wdata (wdata), .wstrb (wstrb),
    .bvalid (bvalid), .bready (bready), .bresp (bresp),
    .arvalid (arvalid), .arready (arready), .araddr (araddr),
    .rvalid (rvalid), .rready (rready), .rdata (rdata), .rresp (rresp),
    .ch_wr_en (ch_wr_en), .ch_waddr (ch_waddr), .ch_wdata (ch_wdata), .ch_wstrb (ch_wstrb),
    .ch_rd_en (ch_rd_en), .ch_raddr (ch_raddr), .ch_rdata (ch_rdata), .ch_rvalid (ch_rvalid),
    .err_cnt (err_cnt)
  );

  initial clk_main_a0 = 1'b0;
  always #5 clk_main_a0 = ~clk_main_a0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_main_a0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_main_n = 1'b0;
    awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    arvalid = 0; araddr = 0; rready = 0; ch_rvalid = 0;
    ch_rdata = {32'h4444_4444, 32'h1234_5678, 32'h2222_2222, 32'h1111_1111};

    // reset state
    cyc(); cyc();
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 1);
    check("rst_arready", arready, 1);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_ch_wr_en", ch_wr_en, 0);
    check("rst_ch_rd_en", ch_rd_en, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_main_n = 1'b1;
    cyc(); cyc(); cyc();
    $display("step reset done");

    // write 0x1004: AW first, W three cycles later
    awvalid = 1; awaddr = 32'h0000_1004;
    cyc();
    check("wr1_awready_low", awready, 0);
    check("wr1_wready_high", wready, 1);
    awvalid = 0;
    cyc(); cyc();
    wvalid = 1; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
    cyc();
    check("wr1_ch_wr_en", ch_wr_en, 4'b0010);
    check("wr1_ch_waddr", ch_waddr, 12'h004);
    check("wr1_ch_wdata", ch_wdata, 32'hA5A5_A5A5);
    check("wr1_ch_wstrb", ch_wstrb, 4'hF);
    check("wr1_bvalid_early", bvalid, 0);
    wvalid = 0;
    cyc();
    check("wr1_ch_wr_en_single", ch_wr_en, 0);
    check("wr1_bvalid", bvalid, 1);
    check("wr1_bresp", bresp, 0);
    bready = 1;
    cyc();
    check("wr1_bvalid_done", bvalid, 0);
    check("wr1_awready_back", awready, 1);
    bready = 0;
    $display("step write 0x1004 done");

    // read 0x2010, channel 2 answers 5 cycles after the request pulse
    arvalid = 1; araddr = 32'h0000_2010;
    cyc();
    check("rd1_arready_low", arready, 0);
    check("rd1_ch_rd_en", ch_rd_en, 4'b0100);
    check("rd1_ch_raddr", ch_raddr, 12'h010);
    arvalid = 0;
    cyc();
    check("rd1_ch_rd_en_single", ch_rd_en, 0);
    check("rd1_ch_raddr_held", ch_raddr, 12'h010);
    ch_rvalid = 4'b0010;
    cyc();
    check("rd1_other_ch_ignored", rvalid, 0);
    ch_rvalid = 0;
    cyc(); cyc(); cyc();
    check("rd1_rvalid_early", rvalid, 0);
    ch_rvalid = 4'b0100;
    cyc();
    check("rd1_rvalid", rvalid, 1);
    check("rd1_rdata", rdata, 32'h1234_5678);
    check("rd1_rresp", rresp, 0);
    ch_rvalid = 0; rready = 1;
    cyc();
    check("rd1_rvalid_done", rvalid, 0);
    check("rd1_arready_back", arready, 1);
    rready = 0;
    $display("step read 0x2010 done");

    // read 0x3000 with no channel response -> timeout
    arvalid = 1; araddr = 32'h0000_3000;
    cyc();
    check("rd2_ch_rd_en", ch_rd_en, 4'b1000);
    arvalid = 0;
    repeat (8) cyc();
    check("rd2_rvalid_before_tmo", rvalid, 0);
    cyc();
    check("rd2_rvalid", rvalid, 1);
    check("rd2_rresp", rresp, 2);
    check("rd2_rdata", rdata, 32'hBAD0_BAD0);
    check("rd2_err_cnt", err_cnt, 1);
    rready = 1;
    cyc();
    rready = 0;
    $display("step read timeout done");

    // write 0x4000: channel 4 does not exist
    awvalid = 1; awaddr = 32'h0000_4000; wvalid = 1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    cyc();
    check("wr2_no_strobe", ch_wr_en, 0);
    check("wr2_awready_low", awready, 0);
    check("wr2_wready_low", wready, 0);
    awvalid = 0; wvalid = 0;
    cyc();
    check("wr2_bvalid", bvalid, 1);
    check("wr2_bresp", bresp, 3);
    check("wr2_err_cnt", err_cnt, 2);
    bready = 1;
    cyc();
    bready = 0;
    $display("step write decerr done");

    // read with upper address bits set -> decode error
    arvalid = 1; araddr = 32'h0001_0000;
    cyc();
    check("rd3_no_rd_en", ch_rd_en, 0);
    check("rd3_rvalid_early", rvalid, 0);
    arvalid = 0;
    cyc();
    check("rd3_rvalid", rvalid, 1);
    check("rd3_rresp", rresp, 3);
    check("rd3_rdata", rdata, 32'hBAD0_BAD0);
    check("rd3_err_cnt", err_cnt, 3);
    rready = 1;
    cyc();
    rready = 0;
    $display("step read decerr done");

    // concurrent write + read, responses back-pressured for 10 cycles
    ch_rdata[63:32] = 32'hCAFE_F00D;
    awvalid = 1; awaddr = 32'h0000_0008; wvalid = 1; wdata = 32'h1111_2222; wstrb = 4'h3;
    arvalid = 1; araddr = 32'h0000_1020;
    cyc();
    check("cc_ch_wr_en", ch_wr_en, 4'b0001);
    check("cc_ch_rd_en", ch_rd_en, 4'b0010);
    check("cc_ch_raddr", ch_raddr, 12'h020);
    check("cc_ch_wstrb", ch_wstrb, 4'h3);
    awaddr = 32'h0000_2000; araddr = 32'h0000_3000;
    ch_rvalid = 4'b0010;
    cyc();
    ch_rdata[63:32] = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      check("cc_bvalid", bvalid, 1);
      check("cc_bresp", bresp, 0);
      check("cc_rvalid", rvalid, 1);
      check("cc_rdata", rdata, 32'hCAFE_F00D);
      check("cc_rresp", rresp, 0);
      check("cc_awready", awready, 0);
      check("cc_arready", arready, 0);
      check("cc_no_wr_en", ch_wr_en, 0);
      check("cc_no_rd_en", ch_rd_en, 0);
      cyc();
    end
    awvalid = 0; wvalid = 0; arvalid = 0; ch_rvalid = 0;
    bready = 1; rready = 1;
    cyc();
    check("cc_bvalid_done", bvalid, 0);
    check("cc_rvalid_done", rvalid, 0);
    check("cc_awready_back", awready, 1);
    check("cc_wready_back", wready, 1);
    check("cc_arready_back", arready, 1);
    check("cc_err_cnt", err_cnt, 3);
    bready = 0; rready = 0;
    ch_rdata[63:32] = 32'h2222_2222;
    $display("step concurrent done");

    // reset while a read is pending
    arvalid = 1; araddr = 32'h0000_2000;
    cyc();
    check("rr_ch_rd_en", ch_rd_en, 4'b0100);
    arvalid = 0;
    cyc(); cyc();
    #2 rst_main_n = 1'b0;
    #1;
    check("rr_arready", arready, 1);
    check("rr_awready", awready, 1);
    check("rr_wready", wready, 1);
    check("rr_rvalid", rvalid, 0);
    check("rr_bvalid", bvalid, 0);
    check("rr_ch_rd_en", ch_rd_en, 0);
    check("rr_ch_raddr", ch_raddr, 0);
    check("rr_rdata", rdata, 0);
    check("rr_ch_wdata", ch_wdata, 0);
    check("rr_err_cnt", err_cnt, 0);
    cyc();
    rst_main_n = 1'b1;
    cyc(); cyc(); cyc();
    check("rr_no_stale_resp", rvalid, 0);
    check("rr_arready_after", arready, 1);
    arvalid = 1; araddr = 32'h0000_2004;
    cyc();
    check("rr2_ch_rd_en", ch_rd_en, 4'b0100);
    check("rr2_ch_raddr", ch_raddr, 12'h004);
    arvalid = 0; ch_rvalid = 4'b0100;
    cyc();
    check("rr2_rvalid", rvalid, 1);
    check("rr2_rdata", rdata, 32'h1234_5678);
    check("rr2_rresp", rresp, 0);
    ch_rvalid = 0; rready = 1;
    cyc();
    check("rr2_rvalid_done", rvalid, 0);
    rready = 0;
    $display("step reset during read done");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
